// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: instruction class
// encodings, forward-select encoding and the select-width derivation.
package id_hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_MULDIV = 2'd2,
    CLS_RSVD   = 2'd3   // decoded as ALU
  } id_class_e;

  // Forward select 0 means "read the register file"; k>0 means "forward from stage k".
  localparam int FWD_RF = 0;

  // Width of a forward select able to encode 0..stages.
  function automatic int fwd_sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_src_match.sv
// Per-source hazard/forwarding resolver: compares one ID source register
// against the in-flight producer slots and the outstanding MUL/DIV result.
module id_src_match
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_RDY   = 2,
  parameter int FWD_SEL_W  = 2
) (
  input  logic [REG_ADDR_W-1:0]                 i_addr,
  input  logic                                  i_used,
  input  logic [FWD_STAGES-1:0]                 i_slot_vld,
  input  logic [FWD_STAGES-1:0][REG_ADDR_W-1:0] i_slot_rd,
  input  logic [FWD_STAGES-1:0]                 i_slot_load,
  input  logic                                  i_md_busy,
  input  logic [REG_ADDR_W-1:0]                 i_md_rd,
  output logic                                  o_hazard,
  output logic [FWD_SEL_W-1:0]                  o_fwd_sel
);

  logic                 w_active;
  logic [FWD_SEL_W-1:0] w_sel;
  logic                 w_sel_load;
  logic                 w_load_haz;
  logic                 w_md_haz;

  // x0 and unused sources never match anything.
  assign w_active = i_used && (i_addr != '0);

  // Youngest-match search: scan oldest to youngest so the lowest stage wins.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    w_sel      = FWD_SEL_W'(FWD_RF);
    w_sel_load = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (w_active && i_slot_vld[k-1] && (i_slot_rd[k-1] == i_addr)) begin
        w_sel      = FWD_SEL_W'(k);
        w_sel_load = i_slot_load[k-1];
      end
    end
  end

  // A load result is forwardable only once it reaches the LOAD_RDY stage.
  assign w_load_haz = w_sel_load && (int'(w_sel) < LOAD_RDY);
  // A pending MUL/DIV result is never forwarded; the reader waits for the regfile.
  assign w_md_haz   = w_active && i_md_busy && (i_md_rd == i_addr);

  assign o_hazard  = w_load_haz || w_md_haz;
  assign o_fwd_sel = w_sel;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard unit: tracks in-flight producers per post-ID stage plus one
// variable-latency MUL/DIV slot, selects forwarding per source, raises stalls
// and counts stall cycles.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int FWD_STAGES = 3,
  parameter  int LOAD_RDY   = 2,
  parameter  int CNT_W      = 32,
  localparam int FWD_SEL_W  = fwd_sel_width(FWD_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rd_we,
  input  logic [1:0]            id_class,
  input  logic                  pipe_adv,
  input  logic                  id_flush,
  input  logic                  md_done,
  output logic                  id_stall,
  output logic [FWD_SEL_W-1:0]  fwd_sel_rs1,
  output logic [FWD_SEL_W-1:0]  fwd_sel_rs2,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [FWD_STAGES-1:0]                 r_slot_vld;
  logic [FWD_STAGES-1:0][REG_ADDR_W-1:0] r_slot_rd;
  logic [FWD_STAGES-1:0]                 r_slot_load;
  logic                                  r_md_busy;
  logic [REG_ADDR_W-1:0]                 r_md_rd;
  logic [CNT_W-1:0]                      r_stall_cnt;

  logic w_is_md;
  logic w_is_load;
  logic w_issue;
  logic w_new_vld;
  logic w_haz_rs1;
  logic w_haz_rs2;
  logic w_waw;
  logic w_struct;

  assign w_is_md   = (id_class == CLS_MULDIV);
  assign w_is_load = (id_class == CLS_LOAD);
  assign w_issue   = id_valid && !id_stall && !id_flush && pipe_adv;
  // MUL/DIV results live in the md tracker, not in the stage slots.
  assign w_new_vld = w_issue && id_rd_we && (id_rd_addr != '0) && !w_is_md;

  id_src_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .LOAD_RDY   (LOAD_RDY),
    .FWD_SEL_W  (FWD_SEL_W)
  ) u_rs1 (
    .i_addr      (id_rs1_addr),
    .i_used      (id_rs1_used),
    .i_slot_vld  (r_slot_vld),
    .i_slot_rd   (r_slot_rd),
    .i_slot_load (r_slot_load),
    .i_md_busy   (r_md_busy),
    .i_md_rd     (r_md_rd),
    .o_hazard    (w_haz_rs1),
    .o_fwd_sel   (fwd_sel_rs1)
  );

  id_src_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .LOAD_RDY   (LOAD_RDY),
    .FWD_SEL_W  (FWD_SEL_W)
  ) u_rs2 (
    .i_addr      (id_rs2_addr),
    .i_used      (id_rs2_used),
    .i_slot_vld  (r_slot_vld),
    .i_slot_rd   (r_slot_rd),
    .i_slot_load (r_slot_load),
    .i_md_busy   (r_md_busy),
    .i_md_rd     (r_md_rd),
    .o_hazard    (w_haz_rs2),
    .o_fwd_sel   (fwd_sel_rs2)
  );

  // Writing the register a MUL/DIV will later write would let the older result win.
  assign w_waw    = id_rd_we && r_md_busy && (id_rd_addr == r_md_rd);
  // Only one MUL/DIV may be outstanding; it may issue in the cycle the old one retires.
  assign w_struct = w_is_md && r_md_busy && !md_done;
  assign id_stall = id_valid && !id_flush && (w_haz_rs1 || w_haz_rs2 || w_waw || w_struct);

  // Slot valid bits: shift toward WB on advance, oldest drops out.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every slot samples
    // its neighbour's pre-edge value regardless of statement order.
    if (rst) begin
      r_slot_vld <= '0;
    end else if (pipe_adv) begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        r_slot_vld[k] <= r_slot_vld[k-1];
      end
      r_slot_vld[0] <= w_new_vld;
    end
  end

  // Slot payload shifts alongside the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: payload is left unreset; it is only observed through a valid bit that is reset.
    if (pipe_adv) begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        r_slot_rd[k]   <= r_slot_rd[k-1];
        r_slot_load[k] <= r_slot_load[k-1];
      end
      r_slot_rd[0]   <= id_rd_addr;
      r_slot_load[0] <= w_is_load;
    end
  end

  // MUL/DIV tracker: a new issue takes priority over a retiring completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_md_busy <= 1'b0;
      r_md_rd   <= '0;
    end else if (w_issue && w_is_md) begin
      r_md_busy <= 1'b1;
      r_md_rd   <= id_rd_addr;
    end else if (md_done) begin
      r_md_busy <= 1'b0;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (id_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign md_busy   = r_md_busy;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench: two scoreboards (LOAD_RDY=2 and LOAD_RDY=3) share one
// stimulus stream; a producer-list model predicts every output every cycle and
// directed literal expectations pin the model.
module tb_id_hazard_scoreboard;

  localparam int FWD_STAGES = 3;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;
  localparam int C_ALU = 0, C_LOAD = 1, C_MD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, pipe_adv, id_flush, md_done;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [1:0] id_class;

  logic        s0, s1, b0, b1;
  logic [1:0]  f1_0, f2_0, f1_1, f2_1;
  logic [31:0] c0, c1;

  int  n_pass  = 0;
  int  n_total = 0;
  bit  started = 1'b0;
  logic [31:0] cnt_before;

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.LOAD_RDY(2)) u_dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_class(id_class),
    .pipe_adv(pipe_adv), .id_flush(id_flush), .md_done(md_done),
    .id_stall(s0), .fwd_sel_rs1(f1_0), .fwd_sel_rs2(f2_0),
    .md_busy(b0), .stall_cnt(c0)
  );

  id_hazard_scoreboard #(.LOAD_RDY(3)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_class(id_class),
    .pipe_adv(pipe_adv), .id_flush(id_flush), .md_done(md_done),
    .id_stall(s1), .fwd_sel_rs1(f1_1), .fwd_sel_rs2(f2_1),
    .md_busy(b1), .stall_cnt(c1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // In-flight producers as a list; age = pipeline stage it currently occupies.
  typedef struct {
    int inst;
    int rd;
    bit ld;
    int age;
  } prod_t;

  prod_t  inflight[$];
  int     m_busy[2] = '{0, 0};
  int     m_mdrd[2] = '{0, 0};
  longint m_cnt[2]  = '{0, 0};
  bit     exp_stall[2];

  function automatic void src_eval(input int inst, input int addr, input bit used,
                                   input int load_rdy, output bit haz, output int sel);
    int best = 0;
    bit best_ld = 1'b0;
    haz = 1'b0;
    if (used && addr != 0) begin
      foreach (inflight[j]) begin
        if (inflight[j].inst == inst && inflight[j].rd == addr &&
            (best == 0 || inflight[j].age < best)) begin
          best    = inflight[j].age;
          best_ld = inflight[j].ld;
        end
      end
      if (best_ld && best < load_rdy) haz = 1'b1;
      if (m_busy[inst] != 0 && m_mdrd[inst] == addr) haz = 1'b1;
    end
    sel = best;
  endfunction

  function automatic void model_eval(input int inst, input int load_rdy,
                                     output bit stall, output int s1_sel, output int s2_sel);
    bit h1, h2, waw, strc;
    src_eval(inst, int'(id_rs1_addr), id_rs1_used, load_rdy, h1, s1_sel);
    src_eval(inst, int'(id_rs2_addr), id_rs2_used, load_rdy, h2, s2_sel);
    waw   = id_rd_we && m_busy[inst] != 0 && int'(id_rd_addr) == m_mdrd[inst];
    strc  = int'(id_class) == C_MD && m_busy[inst] != 0 && !md_done;
    stall = id_valid && !id_flush && (h1 || h2 || waw || strc);
  endfunction

  task automatic model_step();
    prod_t keep[$];
    prod_t np;
    bit    issue;
    if (rst) begin
      inflight.delete();
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_mdrd[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      foreach (inflight[j]) begin
        np = inflight[j];
        if (pipe_adv) np.age++;
        if (np.age <= FWD_STAGES) keep.push_back(np);
      end
      for (int i = 0; i < 2; i++) begin
        issue = id_valid && !exp_stall[i] && !id_flush && pipe_adv;
        if (issue && id_rd_we && id_rd_addr != 0 && int'(id_class) != C_MD) begin
          np.inst = i; np.rd = int'(id_rd_addr); np.ld = (int'(id_class) == C_LOAD); np.age = 1;
          keep.push_back(np);
        end
        if (issue && int'(id_class) == C_MD) begin
          m_busy[i] = 1; m_mdrd[i] = int'(id_rd_addr);
        end else if (md_done) begin
          m_busy[i] = 0;
        end
        if (exp_stall[i] && m_cnt[i] != CNT_MAX) m_cnt[i]++;
      end
      inflight = keep;
    end
  endtask

  // Every cycle: compare both DUTs against the model, then advance the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        bit es;
        int e1, e2;
        model_eval(i, (i == 0) ? 2 : 3, es, e1, e2);
        exp_stall[i] = es;
        check($sformatf("d%0d_stall", i), (i == 0) ? s0 : s1, es);
        check($sformatf("d%0d_md_busy", i), (i == 0) ? b0 : b1, m_busy[i]);
        check($sformatf("d%0d_stall_cnt", i), (i == 0) ? c0 : c1, m_cnt[i]);
        if (!es) begin
          check($sformatf("d%0d_fwd_rs1", i), (i == 0) ? f1_0 : f1_1, e1);
          check($sformatf("d%0d_fwd_rs2", i), (i == 0) ? f2_0 : f2_1, e2);
        end
      end
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drv(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                     input int rd, input bit we, input int cls,
                     input bit adv = 1'b1, input bit fl = 1'b0, input bit mdd = 1'b0);
    id_valid    = v;
    id_rs1_addr = 5'(r1); id_rs1_used = u1;
    id_rs2_addr = 5'(r2); id_rs2_used = u2;
    id_rd_addr  = 5'(rd); id_rd_we    = we;
    id_class    = 2'(cls);
    pipe_adv    = adv; id_flush = fl; md_done = mdd;
    #3;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, C_ALU);
      nxt();
    end
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, C_ALU);
    nxt(); nxt();
    started = 1'b1;
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, C_ALU);
    check("rst_stall", s0, 0);
    check("rst_fwd_rs1", f1_0, 0);
    check("rst_md_busy", b0, 0);
    check("rst_cnt", c0, 0);
    nxt();

    // ALU producer consumed next cycle, and across one bubble.
    drv(1, 0, 0, 0, 0, 5, 1, C_ALU); nxt();
    drv(1, 5, 1, 0, 0, 0, 0, C_ALU);
    check("alu_next_stall", s0, 0);
    check("alu_next_fwd", f1_0, 1);
    nxt();
    drv(1, 0, 0, 0, 0, 10, 1, C_ALU); nxt();
    bubbles(1);
    drv(1, 0, 0, 10, 1, 0, 0, C_ALU);
    check("alu_bubble_fwd", f2_0, 2);
    nxt();
    bubbles(3);

    // Load-use: one stall with LOAD_RDY=2, two with LOAD_RDY=3.
    drv(1, 0, 0, 0, 0, 7, 1, C_LOAD); nxt();
    drv(1, 7, 1, 0, 0, 0, 0, C_ALU);
    check("ld_c1_stall_r2", s0, 1);
    check("ld_c1_stall_r3", s1, 1);
    nxt();
    drv(1, 7, 1, 0, 0, 0, 0, C_ALU);
    check("ld_c2_stall_r2", s0, 0);
    check("ld_c2_fwd_r2", f1_0, 2);
    check("ld_c2_cnt_r2", c0, 1);
    check("ld_c2_stall_r3", s1, 1);
    nxt();
    drv(1, 7, 1, 0, 0, 0, 0, C_ALU);
    check("ld_c3_stall_r3", s1, 0);
    check("ld_c3_fwd_r3", f1_1, 3);
    check("ld_c3_cnt_r3", c1, 2);
    nxt();
    bubbles(3);

    // MUL/DIV reader stalls through md_done, reads regfile afterwards.
    drv(1, 0, 0, 0, 0, 9, 1, C_MD); nxt();
    drv(1, 9, 1, 0, 0, 0, 0, C_ALU);
    check("md_busy_set", b0, 1);
    check("md_rd_stall", s0, 1);
    nxt();
    for (int i = 0; i < 2; i++) begin
      drv(1, 9, 1, 0, 0, 0, 0, C_ALU);
      check("md_rd_stall_hold", s0, 1);
      nxt();
    end
    drv(1, 9, 1, 0, 0, 0, 0, C_ALU, 1'b1, 1'b0, 1'b1);
    check("md_done_cycle_stall", s0, 1);
    nxt();
    drv(1, 9, 1, 0, 0, 0, 0, C_ALU);
    check("md_after_busy", b0, 0);
    check("md_after_stall", s0, 0);
    check("md_after_fwd", f1_0, 0);
    nxt();

    // WAW and structural hazards; new MUL/DIV wins over md_done.
    drv(1, 0, 0, 0, 0, 11, 1, C_MD); nxt();
    drv(1, 0, 0, 0, 0, 11, 1, C_ALU);
    check("waw_stall", s0, 1);
    nxt();
    drv(1, 0, 0, 0, 0, 12, 1, C_MD);
    check("struct_stall", s0, 1);
    nxt();
    drv(1, 0, 0, 0, 0, 12, 1, C_MD, 1'b1, 1'b0, 1'b1);
    check("struct_done_stall", s0, 0);
    nxt();
    drv(1, 0, 0, 12, 1, 0, 0, C_ALU);
    check("md_reissue_busy", b0, 1);
    check("md_reissue_rd_stall", s0, 1);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, C_ALU, 1'b1, 1'b0, 1'b1); nxt();
    bubbles(3);

    // Youngest of two producers wins; x0 never forwards or stalls.
    drv(1, 0, 0, 0, 0, 3, 1, C_ALU); nxt();
    drv(1, 0, 0, 0, 0, 4, 1, C_ALU); nxt();
    drv(1, 0, 0, 0, 0, 3, 1, C_ALU); nxt();
    drv(1, 3, 1, 4, 1, 0, 0, C_ALU);
    check("youngest_fwd_rs1", f1_0, 1);
    check("youngest_fwd_rs2", f2_0, 2);
    nxt();
    drv(1, 0, 0, 0, 0, 0, 1, C_LOAD); nxt();
    drv(1, 0, 1, 0, 1, 0, 0, C_ALU);
    check("x0_stall", s0, 0);
    check("x0_fwd_rs1", f1_0, 0);
    check("x0_fwd_rs2", f2_0, 0);
    nxt();
    bubbles(3);

    // Frozen pipe with a load in slot 1, then flush.
    drv(1, 0, 0, 0, 0, 8, 1, C_LOAD); nxt();
    cnt_before = c0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 8, 1, 0, 0, 0, 0, C_ALU, 1'b0);
      check("frozen_stall", s0, 1);
      nxt();
    end
    drv(1, 8, 1, 0, 0, 0, 0, C_ALU, 1'b0, 1'b1);
    check("flush_stall", s0, 0);
    check("frozen_cnt_delta", c0 - cnt_before, 4);
    nxt();
    drv(1, 8, 1, 0, 0, 0, 0, C_ALU, 1'b1, 1'b1);
    check("flush_adv_stall", s0, 0);
    nxt();
    drv(1, 8, 1, 0, 0, 0, 0, C_ALU);
    check("post_flush_stall", s0, 0);
    check("post_flush_fwd", f1_0, 2);
    nxt();
    bubbles(3);

    // Reset during an outstanding MUL/DIV with a load in flight.
    drv(1, 0, 0, 0, 0, 13, 1, C_MD); nxt();
    drv(1, 0, 0, 0, 0, 14, 1, C_LOAD); nxt();
    rst = 1'b1;
    drv(1, 13, 1, 14, 1, 0, 0, C_ALU); nxt();
    rst = 1'b0;
    drv(1, 13, 1, 14, 1, 0, 0, C_ALU);
    check("rst2_stall_r2", s0, 0);
    check("rst2_busy_r2", b0, 0);
    check("rst2_cnt_r2", c0, 0);
    check("rst2_fwd1_r2", f1_0, 0);
    check("rst2_fwd2_r2", f2_0, 0);
    check("rst2_stall_r3", s1, 0);
    check("rst2_busy_r3", b1, 0);
    check("rst2_cnt_r3", c1, 0);
    nxt();
    bubbles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
